// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared definitions for the pipeline interlock controller: the MDU tracking
// FSM state type, the StallCause encodings and the $zero register number.
// Optional feature macro used by the top level: HAZARD_PERF_CNT_EN.
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  // MDU tracking FSM: RUN while the MDU is idle, MDU_BUSY while counting down
  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mduState_t;

  // StallCause is {mduHazard, loadUse}
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LU   = 2'b01;
  localparam logic [1:0] CAUSE_MDU  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // Register $zero never creates a true dependence
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_mdu_counter.sv
// ---------------------------------------------------------------------------
// mdu_busy_counter
// Tracks how long the multi-cycle multiply/divide unit stays busy after an
// accepted mult/div. An accepted issue loads MDU_LATENCY; the counter then
// decrements every cycle and returns to RUN when it would pass through 1->0.
//
// Ports:
//   clk       core clock
//   rst_n     asynchronous active-low reset
//   issue     accepted mult/div issue this cycle (only honoured in RUN)
//   mduState  current FSM state (RUN / MDU_BUSY)
//   mduBusy   registered busy flag, high exactly MDU_LATENCY cycles
// ---------------------------------------------------------------------------
module mdu_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue,
  output mduState_t mduState,
  output logic      mduBusy
);

  logic [CNT_W-1:0] count;

  // Single-process FSM with the countdown and the registered busy flag.
  // Busy is written alongside the state so it is high exactly while the
  // counter is nonzero, starting the cycle after the issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mduState <= RUN;
      count    <= '0;
      mduBusy  <= 1'b0;
    end else begin
      case (mduState)
        RUN: begin
          if (issue) begin
            mduState <= MDU_BUSY;
            count    <= CNT_W'(MDU_LATENCY);
            mduBusy  <= 1'b1;
          end
        end
        MDU_BUSY: begin
          if (count == CNT_W'(1)) begin
            mduState <= RUN;
            count    <= '0;
            mduBusy  <= 1'b0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          mduState <= RUN;
          count    <= '0;
          mduBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline interlock controller for the 5-stage MIPS32 core. Covers the
// hazards forwarding cannot resolve: load-use, MDU latency, and control
// hazards from jumps and taken branches.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   IFID_RegRs/RegRt   source fields of the instruction in ID
//   ID_UsesRt          ID instruction reads rt
//   ID_Jump            j/jal/jr in ID
//   ID_MduStart        mult/div in ID
//   ID_MduRead         mfhi/mflo in ID
//   IDEX_RegRt         destination rt of the instruction in EX
//   IDEX_MemRead       EX instruction is a load
//   EX_BranchTaken     branch resolved taken in EX
//   PCWrite            PC update enable
//   IFID_Write         IF/ID register enable
//   IDEX_Bubble        zero ID/EX control signals
//   IFID_Flush         squash IF/ID
//   IDEX_Flush         squash ID/EX
//   MDU_Busy           registered MDU busy flag
//   StallCause         {mduHazard, loadUse}
//   StallCycles        (HAZARD_PERF_CNT_EN only) saturating stall count
//   FlushCycles        (HAZARD_PERF_CNT_EN only) saturating IF/ID flush count
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the two perf counters.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_RegRs,
  input  logic [4:0]  IFID_RegRt,
  input  logic        ID_UsesRt,
  input  logic        ID_Jump,
  input  logic        ID_MduStart,
  input  logic        ID_MduRead,
  input  logic [4:0]  IDEX_RegRt,
  input  logic        IDEX_MemRead,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        MDU_Busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCycles,
`endif
  output logic [1:0]  StallCause
);

  mduState_t mduState;
  logic      loadUse;
  logic      mduHazard;
  logic      stall;
  logic      jumpFlush;
  logic      mduIssue;

  mdu_busy_counter #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) uMduCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (mduIssue),
    .mduState (mduState),
    .mduBusy  (MDU_Busy)
  );

  // Hazard detection. Everything is qualified with rst_n so that the
  // outputs show the pass-through values while reset is held.
  always_comb begin
    loadUse   = rst_n && IDEX_MemRead && (IDEX_RegRt != REG_ZERO) &&
                ((IDEX_RegRt == IFID_RegRs) ||
                 (ID_UsesRt && (IDEX_RegRt == IFID_RegRt)));
    mduHazard = rst_n && (mduState == MDU_BUSY) && (ID_MduRead || ID_MduStart);
    stall     = loadUse || mduHazard;
    // A stalled jump simply stays in ID, so it flushes once the stall clears
    jumpFlush = rst_n && ID_Jump && !stall && !EX_BranchTaken;
    // Blocked issues never load the counter; they retry from ID later
    mduIssue  = rst_n && (mduState == RUN) && ID_MduStart && !stall &&
                !EX_BranchTaken && !jumpFlush;
  end

  // Priority mux: taken branch > stall > jump. The MDU countdown keeps
  // running under a branch flush because the MDU op is already past EX.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    StallCause  = CAUSE_NONE;
    if (!rst_n) begin
      PCWrite = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      StallCause  = {mduHazard, loadUse};
    end else if (jumpFlush) begin
      IFID_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters; a stall overridden by a taken branch
  // is not counted as a stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      if (stall && !EX_BranchTaken && (StallCycles != 16'hFFFF)) begin
        StallCycles <= StallCycles + 16'd1;
      end
      if (IFID_Flush && (FlushCycles != 16'hFFFF)) begin
        FlushCycles <= FlushCycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline interlock controller for the 5-stage MIPS32 core. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use dependences, the latency of the multi-cycle multiply/divide unit (MDU), and control hazards from jumps and taken branches. It drives the PC and IF/ID write enables, the ID/EX bubble, and the IF/ID and ID/EX flushes.

Parameters:
MDU_LATENCY, 4, number of cycles the MDU is busy after a mult/div leaves ID (legal range 1..15)
CNT_W, 4, MDU countdown counter width; must hold MDU_LATENCY

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
IFID_RegRs  in  5  rs field of the instruction in ID
IFID_RegRt  in  5  rt field of the instruction in ID
ID_UsesRt  in  1  instruction in ID reads rt as a source
ID_Jump  in  1  j/jal/jr decoded in ID
ID_MduStart  in  1  mult/multu/div/divu in ID
ID_MduRead  in  1  mfhi/mflo in ID
IDEX_RegRt  in  5  destination rt of the instruction in EX
IDEX_MemRead  in  1  instruction in EX is a load
EX_BranchTaken  in  1  branch resolved taken in EX
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
IDEX_Bubble  out  1  zero ID/EX control signals
IFID_Flush  out  1  squash the IF/ID contents
IDEX_Flush  out  1  squash the ID/EX contents
MDU_Busy  out  1  registered; MDU countdown is active
StallCause  out  2  00 none, 01 load-use, 10 MDU, 11 both

Behaviour:
- Clock and reset: single clk domain. rst_n low forces RUN state, counter 0 and MDU_Busy 0 immediately; this applies mid-MDU as well.
- Outputs while rst_n is low: PCWrite=1, IFID_Write=1, all other outputs 0.
- Load-use hazard (LU) when all hold:
  - IDEX_MemRead=1 and IDEX_RegRt!=0
  - IDEX_RegRt==IFID_RegRs, or (ID_UsesRt and IDEX_RegRt==IFID_RegRt)
  - Response: combinational, same cycle. One stall cycle results, because the load advances to MEM next cycle.
- FSM states:
  - RUN: MDU idle.
  - MDU_BUSY: counter nonzero.
- MDU issue:
  - In RUN, ID_MduStart=1 with no stall and no flush in that cycle loads the counter with MDU_LATENCY and moves to MDU_BUSY.
  - An issue blocked by stall or flush does not load the counter.
- MDU_BUSY countdown:
  - Counter decrements every cycle.
  - When the counter is 1, the next state is RUN with counter 0.
  - MDU_Busy is high exactly MDU_LATENCY cycles, starting the cycle after issue.
- MDU hazard (MH): state is MDU_BUSY and (ID_MduRead or ID_MduStart).
- Stall (LU or MH): PCWrite=0, IFID_Write=0, IDEX_Bubble=1. StallCause encodes which of LU/MH are true.
- Taken branch: EX_BranchTaken=1 gives IFID_Flush=1, IDEX_Flush=1 and PCWrite=1.
  - Overrides any stall in the same cycle: IDEX_Bubble=0, StallCause=00.
  - The MDU countdown is not aborted, because the MDU op is already past EX.
- Jump: ID_Jump=1 with no stall and no taken branch gives IFID_Flush=1 (fetched-slot squash).
  - A jump under stall is held and flushes when the stall clears.
- Priority: EX_BranchTaken > stall (LU|MH) > ID_Jump > MDU issue.
- Output timing: all outputs other than MDU_Busy are combinational from the inputs, state and counter.

Optional Feature:
HAZARD_PERF_CNT_EN defined:
- Adds outputs StallCycles (16) and FlushCycles (16), both registered and saturating at 16'hFFFF.
- StallCycles increments on each stall cycle that is not overridden by a branch.
- FlushCycles increments on each cycle with IFID_Flush=1.
- Both reset to 0 on rst_n.
Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state enum (RUN, MDU_BUSY), StallCause code constants, register-number-zero constant.
- One natural sub-module, mdu_busy_counter: load/decrement/busy logic parameterized by MDU_LATENCY and CNT_W.
- LU/MH detection and priority muxing stay in the top module.

Test Plan:
- Load then dependent use: IDEX_MemRead=1, IDEX_RegRt=8, IFID_RegRs=8
  -> 1 cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1, StallCause=01; next cycle normal.
- Load to $zero: IDEX_RegRt=0, IFID_RegRs=0, or rt match with ID_UsesRt=0
  -> no stall, StallCause=00.
- mult issue, then mflo in ID on the next cycle, MDU_LATENCY=4
  -> MDU_Busy high 4 cycles; stall 4 cycles with StallCause=10; mflo proceeds on cycle 5.
- EX_BranchTaken=1 in the same cycle as an LU condition
  -> IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IDEX_Bubble=0, StallCause=00.
- rst_n pulsed low at count 2 of an MDU op
  -> MDU_Busy=0 immediately; after release, mflo passes with no stall.
- ID_Jump=1 during MH stall
  -> IFID_Flush=0 while stalled; IFID_Flush=1 on the first non-stall cycle.
